inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameters: none; instruction index 12 bits, PC 13 bits, instruction 9 bits, all fixed.
REQ-002 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin execution at start_addr.
REQ-005 start_addr  in  12  first instruction index.
REQ-006 stall  in  1  hold current instruction in execute phase.
REQ-007 branch_en  in  1  take branch at end of current execute phase.
REQ-008 branch_rel  in  1  1 = branch_val is a signed offset; 0 = absolute index.
REQ-009 branch_val  in  12  branch target or two's-complement offset.
REQ-010 halt_req  in  1  stop after current instruction.
REQ-011 rom_en  out  1  instruction ROM read enable.
REQ-012 rom_addr  out  12  instruction ROM index; ROM is synchronous, data valid the cycle after rom_en.
REQ-013 rom_data  in  9  instruction ROM read data.
REQ-014 PC  out  13  {index, phase}; PC[0]=0 fetch phase, PC[0]=1 execute phase.
REQ-015 inst_out  out  9  current instruction, stable across both phases.
REQ-016 inst_valid  out  1  inst_out belongs to a running program.
REQ-017 running  out  1  state is RUN.
REQ-018 done  out  1  state is DONE.
REQ-019 instr_count  out  16  retired-instruction counter.

Function
REQ-020 States IDLE, RUN, DONE; registered state, no other states.
REQ-021 IDLE: PC=0, rom_en=0, inst_valid=0; start=1 -> rom_en=1, rom_addr=start_addr, next PC={start_addr,0}, instr_count cleared, next state RUN.
REQ-022 RUN fetch phase (PC[0]=0): inst_out=rom_data combinationally and captured into a hold register; next PC=PC+1 (execute phase); rom_en=0.
REQ-023 RUN execute phase: inst_out=hold register; inst_valid=1 in both phases.
REQ-024 Execute phase with stall=1: PC, hold register, state, instr_count unchanged; rom_en=0; branch_en and halt_req ignored.
REQ-025 Execute phase with stall=0 retires the instruction: instr_count+1, saturating at 16'hFFFF.
REQ-026 Next-index priority on retire: halt_req > branch_en > sequential.
REQ-027 Sequential: next index = index+1 mod 4096 (4095 wraps to 0).
REQ-028 Branch absolute: next index = branch_val; relative: index + sign-extended branch_val mod 4096.
REQ-029 On retire without halt: rom_en=1, rom_addr=next index combinationally in same cycle, next PC={next index,0}.
REQ-030 On retire with halt_req=1: rom_en=0, next state DONE, next PC={index,0}, hold register retained.
REQ-031 DONE: PC, inst_out frozen; inst_valid=0; done=1; start=1 behaves exactly as REQ-021 start from IDLE.
REQ-032 start in RUN ignored.
REQ-033 rom_en never asserted in fetch phase; exactly one ROM read per retired non-halting instruction plus one per accepted start.

Reset
REQ-034 Reset=1 at a posedge -> state IDLE, PC=0, hold register=0, instr_count=0; overrides start, stall, branch, halt in the same cycle.
REQ-035 Reset values of outputs: rom_en=0, rom_addr=0, inst_out=0, inst_valid=0, running=0, done=0, instr_count=0.
REQ-036 Reset asserted mid-RUN (either phase) aborts immediately; no retire counted in that cycle.

Verification
REQ-037 Reset, start with start_addr=12'h010, ROM[16]=9'h1A5, no stall -> PC sequence 0,0x020,0x021,0x022; inst_out=9'h1A5 while PC=0x020/0x021; instr_count=1 after first execute.
REQ-038 Execute at index 12'hFFF, sequential -> rom_addr=0, next PC=0 (wrap), instr_count increments.
REQ-039 Index 12'h005, branch_en=1, branch_rel=1, branch_val=12'hFFE -> next PC=0x006 (index 3); absolute branch_val=12'h100 -> next PC=0x200.
REQ-040 Stall held 3 cycles in execute phase with branch_en=1 -> PC constant, rom_en=0, no count; branch taken on first stall=0 cycle.
REQ-041 halt_req=1 and branch_en=1 together at index 7 -> DONE, PC=0x00E, done=1, inst_valid=0; later start restarts with instr_count=0.
REQ-042 Reset asserted in fetch phase simultaneously with start -> next cycle IDLE, PC=0, all outputs at reset values.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Instruction ROM bus between the fetch unit (master) and a synchronous ROM (slave).
//   rom_en   : read enable, driven by the fetch unit
//   rom_addr : 12-bit instruction index, driven by the fetch unit
//   rom_data : 9-bit read data, valid the cycle after rom_en
interface inst_fetch_if;
  logic       rom_en;
  logic [11:0] rom_addr;
  logic [8:0]  rom_data;

  modport master (output rom_en, output rom_addr, input rom_data);
  modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/inst_fetch.sv
// Two-phase instruction fetch/sequencer.
// Ports:
//   CLK, Reset           : clock, synchronous active-high reset
//   start, start_addr    : begin a program at start_addr (from IDLE or DONE)
//   stall                : hold the current instruction in its execute phase
//   branch_en/rel/val    : branch at the end of execute (absolute or signed offset)
//   halt_req             : stop after the current instruction
//   rom                  : instruction ROM bus (master side)
//   PC                   : {index, phase}, phase 0 = fetch, 1 = execute
//   inst_out, inst_valid : current instruction and its validity
//   running, done        : state is RUN / DONE
//   instr_count          : saturating retired-instruction counter
module inst_fetch (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                start,
  input  logic [11:0]         start_addr,
  input  logic                stall,
  input  logic                branch_en,
  input  logic                branch_rel,
  input  logic [11:0]         branch_val,
  input  logic                halt_req,
  inst_fetch_if.master        rom,
  output logic [12:0]         PC,
  output logic [8:0]          inst_out,
  output logic                inst_valid,
  output logic                running,
  output logic                done,
  output logic [15:0]         instr_count
);

  localparam int unsigned IDX_W  = 12;
  localparam int unsigned PC_W   = 13;
  localparam int unsigned INST_W = 9;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0]    idx;
  logic                exec_ph;
  logic [IDX_W-1:0]    next_idx;

  assign idx     = pc_q[PC_W-1:1];
  assign exec_ph = pc_q[0];

  // Target index on a non-halting retire; 12-bit adds wrap mod 4096.
  always_comb begin
    next_idx = idx + IDX_W'(1);
    if (branch_en) begin
      next_idx = branch_rel ? (idx + branch_val) : branch_val;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and ROM request logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    rom.rom_en   = 1'b0;
    rom.rom_addr = '0;
    unique case (state_q)
      S_RUN: begin
        if (!exec_ph) begin
          hold_d = rom.rom_data;
          pc_d   = pc_q + PC_W'(1);
        end else if (!stall) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (halt_req) begin
            state_d = S_DONE;
            pc_d    = {idx, 1'b0};
          end else begin
            rom.rom_en   = 1'b1;
            rom.rom_addr = next_idx;
            pc_d         = {next_idx, 1'b0};
          end
        end
      end
      default: begin
        // IDLE and DONE accept start identically.
        if (start) begin
          rom.rom_en   = 1'b1;
          rom.rom_addr = start_addr;
          pc_d         = {start_addr, 1'b0};
          cnt_d        = '0;
          state_d      = S_RUN;
        end
      end
    endcase
  end

  // Fetch phase forwards ROM data directly; otherwise show the held instruction.
  assign inst_out    = (state_q == S_RUN && !exec_ph) ? rom.rom_data : hold_q;
  assign PC          = pc_q;
  assign inst_valid  = (state_q == S_RUN);
  assign running     = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign instr_count = cnt_q;

endmodule
